step_gen: RTL and testbench

Debounced single-step clock generator that sits directly upstream of the CPU and replaces ad-hoc button sampling in the top level. It takes the raw push-button and synchronizes and debounces it. Each accepted press produces exactly one single-cycle step pulse plus a stretched step clock of fixed width, which the top level routes to the CPU clock input (the single-step clock the CPU advances on). It also keeps an 8-bit count of accepted steps for display.

---
 rtl/step_gen.sv | 108 ++++++++++
 tb/tb_step_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_gen.sv
// Debounced single-step generator: synchronizes a raw push-button, accepts one
// press at a time and emits a one-cycle step pulse plus a stretched step clock.
module step_gen #(
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int STEP_HIGH_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic       step_pulse,
    output logic       step_clk,
    output logic [7:0] ticks,
    output logic       busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = (STEP_HIGH_CYCLES > 1) ? $clog2(STEP_HIGH_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX = HW'(STEP_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HIGH,
        HOLD,
        RELEASE_DB
    } state_t;

    state_t        r_state;
    logic          r_s1;
    logic          r_s2;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;

    // NOTE: every output is a flop so step_clk is glitch-free; non-blocking
    // assignments keep all of them updating together on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_dcnt     <= '0;
            r_hcnt     <= '0;
            step_pulse <= 1'b0;
            step_clk   <= 1'b0;
            ticks      <= 8'd0;
            busy       <= 1'b0;
        end else begin
            r_s1       <= button;
            r_s2       <= r_s1;
            step_pulse <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_s2) begin
                        r_state <= PRESS_DB;
                        r_dcnt  <= '0;
                        busy    <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!r_s2) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else if (r_dcnt == DCNT_MAX) begin
                        r_state    <= HIGH;
                        step_pulse <= 1'b1;
                        step_clk   <= 1'b1;
                        ticks      <= ticks + 8'd1;
                        r_hcnt     <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                // Button is deliberately ignored while the step clock is high.
                HIGH: begin
                    if (r_hcnt == HCNT_MAX) begin
                        r_state  <= HOLD;
                        step_clk <= 1'b0;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!r_s2) begin
                        r_state <= RELEASE_DB;
                        r_dcnt  <= '0;
                    end
                end
                RELEASE_DB: begin
                    if (r_s2) begin
                        r_state <= HOLD;
                    end else if (r_dcnt == DCNT_MAX) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_gen.sv
// Self-checking bench for step_gen: directed scenarios plus random bouncy input,
// compared cycle by cycle against a run-length behavioural model.
module tb_step_gen;

    localparam int D = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       button = 1'b0;
    logic       step_pulse;
    logic       step_clk;
    logic [7:0] ticks;
    logic       busy;

    int checks = 0;
    int errors = 0;

    step_gen #(.DEBOUNCE_CYCLES(D), .STEP_HIGH_CYCLES(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .step_pulse (step_pulse),
        .step_clk   (step_clk),
        .ticks      (ticks),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [10:0] got;
    assign got = {step_pulse, step_clk, ticks, busy};

    // Behavioural model: a press is accepted after D+1 consecutive synchronized
    // high samples while idle; the step clock then lasts H edges; the unit is
    // ready again after D+1 consecutive low samples once the clock has dropped.
    logic       m_s1, m_s2;
    int         m_mode;       // 0 waiting for press, 1 clock high, 2 waiting for release
    int         m_ones, m_zeros, m_left;
    logic       m_pulse, m_clk, m_busy;
    logic [7:0] m_ticks;

    function automatic logic [10:0] exp_vec();
        return {m_pulse, m_clk, m_ticks, m_busy};
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_mode = 0; m_ones = 0; m_zeros = 0; m_left = 0;
        m_pulse = 0; m_clk = 0; m_busy = 0; m_ticks = 0;
    endtask

    task automatic model_edge();
        logic s = m_s2;
        m_pulse = 0;
        case (m_mode)
            0: begin
                m_ones = s ? m_ones + 1 : 0;
                m_busy = (m_ones > 0);
                if (m_ones == D + 1) begin
                    m_pulse = 1; m_clk = 1; m_ticks = m_ticks + 8'd1;
                    m_left = H; m_ones = 0; m_mode = 1; m_busy = 1;
                end
            end
            1: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_clk = 0; m_mode = 2; m_zeros = 0;
                end
            end
            default: begin
                m_zeros = s ? 0 : m_zeros + 1;
                if (m_zeros == D + 1) begin
                    m_mode = 0; m_busy = 0; m_zeros = 0;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = button;
    endtask

    // Drives one cycle of stimulus; leaves time at 1 unit after the edge.
    task automatic step(input logic b);
        button = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b0;
        button = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL reset_state got %b required %b", got, 11'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_clean_press();
        for (int e = 1; e <= 20; e++) begin
            step(1'b1);
            checks++;
            if (step_pulse !== (e == 7) || step_clk !== (e >= 7 && e <= 9)) begin
                errors++;
                $display("FAIL clean_timing edge %0d got pulse=%b clk=%b required pulse=%b clk=%b",
                         e, step_pulse, step_clk, (e == 7), (e >= 7 && e <= 9));
            end
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL clean_model edge %0d got %b required %b", e, got, exp_vec());
            end
        end
        for (int e = 0; e < 12; e++) begin
            step(1'b0);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL clean_release_model cyc %0d got %b required %b", e, got, exp_vec());
            end
        end
        checks++;
        if (ticks !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_end got ticks=%0d busy=%b required ticks=1 busy=0", ticks, busy);
        end
    endtask

    task automatic test_bounce_reject();
        int bad = 0;
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 13; c++) begin
                step(c < 3);
                if (step_pulse !== 1'b0 || step_clk !== 1'b0) bad++;
                checks++;
                if (got !== exp_vec()) begin
                    errors++;
                    $display("FAIL bounce_model rep %0d cyc %0d got %b required %b", r, c, got, exp_vec());
                end
            end
        end
        checks++;
        if (bad != 0 || ticks !== 8'd0) begin
            errors++;
            $display("FAIL bounce_reject got bad_cycles=%0d ticks=%0d required 0 and 0", bad, ticks);
        end
    endtask

    task automatic test_long_hold();
        int np = 0, nh = 0;
        apply_reset();
        for (int c = 0; c < 200; c++) begin
            step(1'b1);
            if (step_pulse === 1'b1) np++;
            if (step_clk === 1'b1) nh++;
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL hold_model cyc %0d got %b required %b", c, got, exp_vec());
            end
        end
        checks++;
        if (np != 1 || nh != 3 || ticks !== 8'd1) begin
            errors++;
            $display("FAIL long_hold got pulses=%0d clk_high=%0d ticks=%0d required 1 3 1", np, nh, ticks);
        end
        for (int c = 0; c < 12; c++) step(1'b0);
    endtask

    task automatic test_release_bounce();
        int np = 0;
        logic [4:0] pat [$];
        apply_reset();
        for (int c = 0; c < 15; c++) pat.push_back(5'h1);
        for (int c = 0; c < 4; c++)  pat.push_back(5'h0);
        for (int c = 0; c < 2; c++)  pat.push_back(5'h1);
        for (int c = 0; c < 14; c++) pat.push_back(5'h0);
        foreach (pat[i]) begin
            step(pat[i][0]);
            if (step_pulse === 1'b1) np++;
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL relbounce_model cyc %0d got %b required %b", i, got, exp_vec());
            end
            // Re-assertion lands in the middle of release debounce: must stay busy.
            if (i == 23) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL relbounce_busy got %b required 1", busy);
                end
            end
        end
        checks++;
        if (np != 1 || ticks !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_bounce got pulses=%0d ticks=%0d busy=%b required 1 1 0", np, ticks, busy);
        end
    endtask

    task automatic test_wrap();
        int np = 0;
        apply_reset();
        for (int p = 1; p <= 256; p++) begin
            for (int c = 0; c < 22; c++) begin
                step(c < 12);
                if (step_pulse === 1'b1) np++;
                checks++;
                if (got !== exp_vec()) begin
                    errors++;
                    $display("FAIL wrap_model press %0d cyc %0d got %b required %b", p, c, got, exp_vec());
                end
            end
            if (p == 255) begin
                checks++;
                if (ticks !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255 got %0d required 255", ticks);
                end
            end
        end
        checks++;
        if (ticks !== 8'd0 || np != 256) begin
            errors++;
            $display("FAIL wrap_256 got ticks=%0d pulses=%0d required 0 256", ticks, np);
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        int   n = 0;
        while (n < 3000) begin
            int len = $urandom_range(1, 9);
            lvl = ~lvl;
            for (int c = 0; c < len; c++) begin
                step(lvl);
                n++;
                checks++;
                if (got !== exp_vec()) begin
                    errors++;
                    $display("FAIL random_model cyc %0d got %b required %b", n, got, exp_vec());
                end
            end
        end
        for (int c = 0; c < 20; c++) step(1'b0);
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 22; c++) step(c < 12);
        for (int c = 0; c < 20 && step_clk !== 1'b1; c++) step(1'b1);
        checks++;
        if (step_clk !== 1'b1 || ticks !== 8'd5) begin
            errors++;
            $display("FAIL async_setup got clk=%b ticks=%0d required 1 5", step_clk, ticks);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL async_reset got %b required %b", got, 11'd0);
        end
        button = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step(c < 12);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL async_after_model cyc %0d got %b required %b", c, got, exp_vec());
            end
        end
        checks++;
        if (ticks !== 8'd1) begin
            errors++;
            $display("FAIL async_after_press got ticks=%0d required 1", ticks);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_long_hold();
        test_release_bounce();
        test_wrap();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
